// File: rtl/wg_dealloc_tracker_pkg.sv
// Shared dispatcher definitions for the workgroup dealloc tracker:
// width constants, tracking-table entry layout and dealloc request layout.
package wg_dealloc_tracker_pkg;

    localparam int NUMBER_CU       = 64;
    localparam int CU_ID_WIDTH     = $clog2(NUMBER_CU);
    localparam int WG_ID_WIDTH     = 10;
    localparam int WF_COUNT_WIDTH  = 4;
    localparam int FIFO_ADDR_WIDTH = 3;

    // One tracking-table entry per workgroup id.
    typedef struct packed {
        logic                      live;
        logic [WF_COUNT_WIDTH-1:0] remaining;
        logic [CU_ID_WIDTH-1:0]    cu_id;
    } wg_entry_t;

    // Request handed to the workgroup resource table.
    typedef struct packed {
        logic [WG_ID_WIDTH-1:0] wg_id;
        logic [CU_ID_WIDTH-1:0] cu_id;
    } dealloc_req_t;

endpackage

// File: rtl/wg_dealloc_tracker_if.sv
// Dispatcher-side bus of the dealloc tracker: alloc notifications,
// wavefront-done stream, dealloc request stream and error pulse.
// master = the tracker, slave = dispatcher / resource-table side.
interface wg_dealloc_tracker_if #(
    parameter int CU_ID_WIDTH    = wg_dealloc_tracker_pkg::CU_ID_WIDTH,
    parameter int WG_ID_WIDTH    = wg_dealloc_tracker_pkg::WG_ID_WIDTH,
    parameter int WF_COUNT_WIDTH = wg_dealloc_tracker_pkg::WF_COUNT_WIDTH
);
    logic                      alloc_valid;
    logic [WG_ID_WIDTH-1:0]    alloc_wg_id;
    logic [CU_ID_WIDTH-1:0]    alloc_cu_id;
    logic [WF_COUNT_WIDTH-1:0] alloc_wf_count;
    logic                      wf_done_valid;
    logic [WG_ID_WIDTH-1:0]    wf_done_wg_id;
    logic                      wf_done_ready;
    logic                      dealloc_valid;
    logic [WG_ID_WIDTH-1:0]    dealloc_wg_id;
    logic [CU_ID_WIDTH-1:0]    dealloc_cu_id;
    logic                      dealloc_ready;
    logic                      err;

    modport master (
        input  alloc_valid, alloc_wg_id, alloc_cu_id, alloc_wf_count,
        input  wf_done_valid, wf_done_wg_id, dealloc_ready,
        output wf_done_ready, dealloc_valid, dealloc_wg_id, dealloc_cu_id, err
    );

    modport slave (
        output alloc_valid, alloc_wg_id, alloc_cu_id, alloc_wf_count,
        output wf_done_valid, wf_done_wg_id, dealloc_ready,
        input  wf_done_ready, dealloc_valid, dealloc_wg_id, dealloc_cu_id, err
    );

endinterface

// File: rtl/wg_dealloc_fifo.sv
// Synchronous FIFO with occupancy count, used as the dealloc request queue.
// Push on a full FIFO and pop on an empty FIFO are ignored.
module wg_dealloc_fifo #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [WIDTH-1:0]    push_data,
    input  logic                pop,
    output logic [WIDTH-1:0]    pop_data,
    output logic                empty,
    output logic                full,
    output logic [ADDR_WIDTH:0] count
);
    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  do_push, do_pop;

    // Next-state pointers and occupancy from the gated push/pop requests.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_push  = push && !full;
        do_pop   = pop && !empty;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + (ADDR_WIDTH+1)'(do_push) - (ADDR_WIDTH+1)'(do_pop);
    end

    // Pointer and count registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state flops use non-blocking assignment so all of them sample together.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write port.
    // NOTE: storage is not reset; an entry is only read after it has been pushed.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign empty    = (count_q == '0);
    assign full     = (count_q == (ADDR_WIDTH+1)'(DEPTH));
    assign count    = count_q;

endmodule

// File: rtl/wg_dealloc_tracker.sv
// Workgroup dealloc tracker: counts outstanding wavefronts per workgroup
// and queues a dealloc request when the last one retires.
// Optional build macro WG_DEALLOC_ERR_CHECK_EN enables the err pulse
// (done on non-live entry, alloc on live entry, zero wf_count, alloc/s1
// same-entry collision); without it err is tied low.
module wg_dealloc_tracker #(
    parameter int NUMBER_CU       = wg_dealloc_tracker_pkg::NUMBER_CU,
    parameter int CU_ID_WIDTH     = $clog2(NUMBER_CU),
    parameter int WG_ID_WIDTH     = wg_dealloc_tracker_pkg::WG_ID_WIDTH,
    parameter int WF_COUNT_WIDTH  = wg_dealloc_tracker_pkg::WF_COUNT_WIDTH,
    parameter int FIFO_ADDR_WIDTH = wg_dealloc_tracker_pkg::FIFO_ADDR_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    wg_dealloc_tracker_if.master bus
);
    localparam int NUM_WG     = 2**WG_ID_WIDTH;
    localparam int FIFO_DEPTH = 2**FIFO_ADDR_WIDTH;
    localparam int OCC_W      = FIFO_ADDR_WIDTH + 2;

    // Tracking table: live bits are reset, payload fields are not.
    logic [NUM_WG-1:0]         live_q, live_d;
    logic [WF_COUNT_WIDTH-1:0] rem_q [NUM_WG];
    logic [CU_ID_WIDTH-1:0]    cu_q  [NUM_WG];

    // Done stage s1.
    logic                   s1_valid_q, s1_valid_d;
    logic [WG_ID_WIDTH-1:0] s1_wg_q, s1_wg_d;

    wg_dealloc_tracker_pkg::wg_entry_t    s1_entry;
    wg_dealloc_tracker_pkg::dealloc_req_t push_req, fifo_head;
    logic [WF_COUNT_WIDTH-1:0] s1_rem_dec;
    logic                      alloc_wr, collide, s1_upd, s1_free, s1_wb;
    logic                      done_fire, fifo_empty, fifo_full, fifo_pop;
    logic [FIFO_ADDR_WIDTH:0]  fifo_count;
    logic [OCC_W-1:0]          occupancy;

    // Room for a push is reserved for s1 before a new done is accepted.
    assign occupancy         = OCC_W'(fifo_count) + OCC_W'(s1_valid_q);
    assign bus.wf_done_ready = occupancy < OCC_W'(FIFO_DEPTH);
    assign done_fire         = bus.wf_done_valid && bus.wf_done_ready;

    // s1 table lookup, decrement, and live-bit / capture next state.
    always_comb begin
        s1_entry.live      = live_q[s1_wg_q];
        s1_entry.remaining = rem_q[s1_wg_q];
        s1_entry.cu_id     = cu_q[s1_wg_q];
        s1_rem_dec         = s1_entry.remaining - WF_COUNT_WIDTH'(1);

        alloc_wr = bus.alloc_valid && (bus.alloc_wf_count != '0);
        collide  = s1_valid_q && alloc_wr && (bus.alloc_wg_id == s1_wg_q);
        s1_upd   = s1_valid_q && s1_entry.live && !collide;
        s1_free  = s1_upd && (s1_rem_dec == '0);
        s1_wb    = s1_upd && !s1_free;

        push_req.wg_id = s1_wg_q;
        push_req.cu_id = s1_entry.cu_id;

        live_d = live_q;
        if (s1_free)  live_d[s1_wg_q]         = 1'b0;
        if (alloc_wr) live_d[bus.alloc_wg_id] = 1'b1;

        s1_valid_d = done_fire;
        s1_wg_d    = done_fire ? bus.wf_done_wg_id : s1_wg_q;
    end

    // Live bits and s1 stage registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_wg_q    <= '0;
        end else begin
            live_q     <= live_d;
            s1_valid_q <= s1_valid_d;
            s1_wg_q    <= s1_wg_d;
        end
    end

    // Table payload write ports: s1 write-back and alloc (never the same entry).
    always_ff @(posedge clk) begin
        if (s1_wb) rem_q[s1_wg_q] <= s1_rem_dec;
        if (alloc_wr) begin
            rem_q[bus.alloc_wg_id] <= bus.alloc_wf_count;
            cu_q[bus.alloc_wg_id]  <= bus.alloc_cu_id;
        end
    end

    assign fifo_pop = bus.dealloc_valid && bus.dealloc_ready;

    wg_dealloc_fifo #(
        .WIDTH      ($bits(wg_dealloc_tracker_pkg::dealloc_req_t)),
        .ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (s1_free),
        .push_data (push_req),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    // Head is masked while empty so the idle request reads as zero.
    assign bus.dealloc_valid = !fifo_empty;
    assign bus.dealloc_wg_id = fifo_empty ? '0 : fifo_head.wg_id;
    assign bus.dealloc_cu_id = fifo_empty ? '0 : fifo_head.cu_id;

`ifdef WG_DEALLOC_ERR_CHECK_EN
    logic err_q, err_d;

    // Protocol violations seen at this edge, registered into a one-cycle pulse.
    always_comb begin
        err_d = (s1_valid_q && !s1_entry.live)
              || (bus.alloc_valid && (bus.alloc_wf_count == '0))
              || (alloc_wr && live_q[bus.alloc_wg_id])
              || collide;
    end

    // Error pulse register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    // fifo_full is implied by wf_done_ready gating and needs no further use.
    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_wg_dealloc_tracker.sv
// Directed bench for wg_dealloc_tracker with a cycle-level reference model
// and a scoreboard queue of expected dealloc requests.
module tb_wg_dealloc_tracker;
    import wg_dealloc_tracker_pkg::*;

    localparam int DEPTH  = 2**FIFO_ADDR_WIDTH;
    localparam int NUM_WG = 2**WG_ID_WIDTH;
`ifdef WG_DEALLOC_ERR_CHECK_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wg_dealloc_tracker_if bus ();

    wg_dealloc_tracker dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    bit           m_live [NUM_WG];
    int           m_rem  [NUM_WG];
    int           m_cu   [NUM_WG];
    bit           m_s1_v;
    bit           m_s1_push;
    dealloc_req_t m_s1_req;
    dealloc_req_t exp_q [$];
    logic [2:0]   err_sched;
    bit           last_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NUM_WG; i++) begin
            m_live[i] = 1'b0;
            m_rem[i]  = 0;
            m_cu[i]   = 0;
        end
        m_s1_v    = 1'b0;
        m_s1_push = 1'b0;
        err_sched = '0;
        exp_q.delete();
    endtask

    // Compare this cycle's outputs, advance the model over the coming edge, then
    // move to the next falling edge. Inputs must already be driven.
    task automatic step();
        bit exp_ready;
        int w;
        exp_ready = (exp_q.size() + int'(m_s1_v)) < DEPTH;
        check("wf_done_ready", 32'(bus.wf_done_ready), 32'(exp_ready));
        check("dealloc_valid", 32'(bus.dealloc_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check("dealloc_wg_id", 32'(bus.dealloc_wg_id), 32'(exp_q[0].wg_id));
            check("dealloc_cu_id", 32'(bus.dealloc_cu_id), 32'(exp_q[0].cu_id));
        end
        check("err", 32'(bus.err), ERR_ON ? 32'(err_sched[0]) : 32'(0));
        last_acc = bus.wf_done_valid && exp_ready;
        if (rst) begin
            clear_model();
            last_acc = 1'b0;
        end else begin
            if (exp_q.size() != 0 && bus.dealloc_ready) void'(exp_q.pop_front());
            if (m_s1_v && m_s1_push) exp_q.push_back(m_s1_req);
            if (bus.alloc_valid) begin
                w = int'(bus.alloc_wg_id);
                if (bus.alloc_wf_count == '0) begin
                    err_sched[1] = 1'b1;
                end else begin
                    if (m_live[w]) err_sched[1] = 1'b1;
                    m_live[w] = 1'b1;
                    m_rem[w]  = int'(bus.alloc_wf_count);
                    m_cu[w]   = int'(bus.alloc_cu_id);
                end
            end
            m_s1_v    = last_acc;
            m_s1_push = 1'b0;
            if (last_acc) begin
                w = int'(bus.wf_done_wg_id);
                if (m_live[w]) begin
                    m_rem[w]--;
                    if (m_rem[w] == 0) begin
                        m_live[w]      = 1'b0;
                        m_s1_push      = 1'b1;
                        m_s1_req.wg_id = WG_ID_WIDTH'(w);
                        m_s1_req.cu_id = CU_ID_WIDTH'(m_cu[w]);
                    end
                end else begin
                    err_sched[2] = 1'b1;
                end
            end
            err_sched = err_sched >> 1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_alloc(input int wg, input int cu, input int cnt);
        bus.alloc_valid    = 1'b1;
        bus.alloc_wg_id    = WG_ID_WIDTH'(wg);
        bus.alloc_cu_id    = CU_ID_WIDTH'(cu);
        bus.alloc_wf_count = WF_COUNT_WIDTH'(cnt);
        step();
        bus.alloc_valid    = 1'b0;
    endtask

    // Hold wf_done_valid until accepted, bounded by a cycle budget.
    task automatic wait_accept();
        bit ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            step();
            ok = last_acc;
        end
        check("done_accepted", 32'(ok), 32'(1));
    endtask

    task automatic do_done(input int wg);
        bus.wf_done_valid = 1'b1;
        bus.wf_done_wg_id = WG_ID_WIDTH'(wg);
        wait_accept();
        bus.wf_done_valid = 1'b0;
    endtask

    initial begin
        bit saw_stall;
        rst                = 1'b1;
        bus.alloc_valid    = 1'b0;
        bus.alloc_wg_id    = '0;
        bus.alloc_cu_id    = '0;
        bus.alloc_wf_count = '0;
        bus.wf_done_valid  = 1'b0;
        bus.wf_done_wg_id  = '0;
        bus.dealloc_ready  = 1'b1;
        clear_model();
        #1;
        check("rst_wf_done_ready", 32'(bus.wf_done_ready), 32'(1));
        check("rst_dealloc_valid", 32'(bus.dealloc_valid), 32'(0));
        check("rst_dealloc_wg_id", 32'(bus.dealloc_wg_id), 32'(0));
        check("rst_dealloc_cu_id", 32'(bus.dealloc_cu_id), 32'(0));
        check("rst_err",           32'(bus.err),           32'(0));
        step();
        step();
        rst = 1'b0;
        step();

        // Two-wavefront workgroup, dones back to back, consumer always ready.
        do_alloc(5, 3, 2);
        do_done(5);
        do_done(5);
        repeat (4) step();

        // Fill the queue with consumer stalled, then drain in order.
        bus.dealloc_ready = 1'b0;
        for (int i = 0; i < 9; i++) do_alloc(i, i + 1, 1);
        saw_stall = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bus.wf_done_valid = 1'b1;
            bus.wf_done_wg_id = WG_ID_WIDTH'(i);
            if (i == 8) begin
                repeat (3) begin
                    if (bus.wf_done_ready === 1'b0) saw_stall = 1'b1;
                    step();
                end
                check("ready_stalled_when_full", 32'(saw_stall), 32'(1));
                bus.dealloc_ready = 1'b1;
            end
            wait_accept();
        end
        bus.wf_done_valid = 1'b0;
        repeat (12) step();

        // Alloc and its only done at the same edge.
        bus.alloc_valid    = 1'b1;
        bus.alloc_wg_id    = WG_ID_WIDTH'(7);
        bus.alloc_cu_id    = CU_ID_WIDTH'(2);
        bus.alloc_wf_count = WF_COUNT_WIDTH'(1);
        bus.wf_done_valid  = 1'b1;
        bus.wf_done_wg_id  = WG_ID_WIDTH'(7);
        step();
        check("same_edge_accept", 32'(last_acc), 32'(1));
        bus.alloc_valid    = 1'b0;
        bus.wf_done_valid  = 1'b0;
        repeat (4) step();

        // Done for a never-allocated workgroup, and a zero-count alloc.
        do_done(20);
        repeat (4) step();
        do_alloc(50, 1, 0);
        repeat (3) step();

        // Reset with queued requests and a live entry.
        bus.dealloc_ready = 1'b0;
        do_alloc(30, 4, 1);
        do_alloc(31, 5, 1);
        do_alloc(32, 6, 1);
        do_alloc(40, 7, 3);
        do_done(30);
        do_done(31);
        do_done(32);
        repeat (3) step();
        rst = 1'b1;
        #1;
        check("midrst_dealloc_valid", 32'(bus.dealloc_valid), 32'(0));
        check("midrst_wf_done_ready", 32'(bus.wf_done_ready), 32'(1));
        clear_model();
        @(negedge clk);
        step();
        rst = 1'b0;
        bus.dealloc_ready = 1'b1;
        step();
        do_done(40);
        repeat (5) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
